zap_load_align_main: RTL and testbench

// - Memory-response stage. Sits directly downstream of the post-ALU stage and upstream of writeback.
// - Takes the registered LD/ST context plus the data-cache read word, lane-selects and extends

---
 rtl/zap_load_align_main_if.sv | 73 +++++++
 rtl/zap_load_align_main.sv | 177 +++++++++++++++++
 tb/tb_zap_load_align_main.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/zap_load_align_main_if.sv
// Bundle between the post-ALU stage, the DCACHE response and writeback for the load-align stage.
// i_* are driven toward the stage (master side); o_* are the registered writeback packet.
interface zap_load_align_main_if #(
  parameter int unsigned PHY_REGS = 32'd46,
  parameter int unsigned FLAG_WDT = 32'd32
);
  localparam int unsigned IW = $clog2(PHY_REGS);

  logic                i_clear_from_writeback;
  logic                i_data_stall;
  logic                i_data_mem_fault;
  logic [31:0]         i_data_rd_dat;
  logic                i_dav_ff;
  logic                i_uop_last;
  logic [31:0]         i_alu_result_ff;
  logic [FLAG_WDT-1:0] i_flags_ff;
  logic [IW-1:0]       i_destination_index_ff;
  logic [IW-1:0]       i_mem_srcdest_index_ff;
  logic                i_mem_load_ff;
  logic [31:0]         i_mem_address_ff;
  logic                i_mem_ubyte_enable_ff;
  logic                i_mem_sbyte_enable_ff;
  logic                i_mem_uhalfword_enable_ff;
  logic                i_mem_shalfword_enable_ff;
  logic [31:0]         i_pc_plus_8_ff;
  logic                i_abt_ff;
  logic                i_irq_ff;
  logic                i_fiq_ff;
  logic                i_swi_ff;
  logic                i_und_ff;

  logic                o_dav_ff;
  logic                o_uop_last;
  logic [31:0]         o_alu_result_ff;
  logic [FLAG_WDT-1:0] o_flags_ff;
  logic [IW-1:0]       o_destination_index_ff;
  logic [IW-1:0]       o_mem_srcdest_index_ff;
  logic                o_mem_load_ff;
  logic [31:0]         o_pc_plus_8_ff;
  logic                o_abt_ff;
  logic                o_irq_ff;
  logic                o_fiq_ff;
  logic                o_swi_ff;
  logic                o_und_ff;
  logic [31:0]         o_mem_rd_data_ff;
  logic                o_dabt_ff;

  modport master (
    output i_clear_from_writeback, i_data_stall, i_data_mem_fault, i_data_rd_dat,
    output i_dav_ff, i_uop_last, i_alu_result_ff, i_flags_ff,
    output i_destination_index_ff, i_mem_srcdest_index_ff, i_mem_load_ff, i_mem_address_ff,
    output i_mem_ubyte_enable_ff, i_mem_sbyte_enable_ff,
    output i_mem_uhalfword_enable_ff, i_mem_shalfword_enable_ff,
    output i_pc_plus_8_ff, i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff, i_und_ff,
    input  o_dav_ff, o_uop_last, o_alu_result_ff, o_flags_ff,
    input  o_destination_index_ff, o_mem_srcdest_index_ff, o_mem_load_ff, o_pc_plus_8_ff,
    input  o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff,
    input  o_mem_rd_data_ff, o_dabt_ff
  );

  modport slave (
    input  i_clear_from_writeback, i_data_stall, i_data_mem_fault, i_data_rd_dat,
    input  i_dav_ff, i_uop_last, i_alu_result_ff, i_flags_ff,
    input  i_destination_index_ff, i_mem_srcdest_index_ff, i_mem_load_ff, i_mem_address_ff,
    input  i_mem_ubyte_enable_ff, i_mem_sbyte_enable_ff,
    input  i_mem_uhalfword_enable_ff, i_mem_shalfword_enable_ff,
    input  i_pc_plus_8_ff, i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff, i_und_ff,
    output o_dav_ff, o_uop_last, o_alu_result_ff, o_flags_ff,
    output o_destination_index_ff, o_mem_srcdest_index_ff, o_mem_load_ff, o_pc_plus_8_ff,
    output o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff,
    output o_mem_rd_data_ff, o_dabt_ff
  );
endinterface

// File: rtl/zap_load_align_main.sv
// Memory-response stage: lane-selects/extends load data and registers the writeback packet.
// Optional macro ZAP_UNALIGNED_ROTATE_EN: unaligned word loads rotate right by 8*addr[1:0].
module zap_load_align_main #(
  parameter int unsigned PHY_REGS = 32'd46,
  parameter int unsigned FLAG_WDT = 32'd32
) (
  input logic                  i_clk,
  input logic                  i_reset,
  zap_load_align_main_if.slave bus
);

  localparam int unsigned IW = $clog2(PHY_REGS);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SLEEP = 1'b1;

  typedef struct packed {
    logic                dav;
    logic                uop_last;
    logic [31:0]         alu_result;
    logic [FLAG_WDT-1:0] flags;
    logic [IW-1:0]       destination_index;
    logic [IW-1:0]       mem_srcdest_index;
    logic                mem_load;
    logic [31:0]         pc_plus_8;
    logic                abt;
    logic                irq;
    logic                fiq;
    logic                swi;
    logic                und;
    logic [31:0]         mem_rd_data;
    logic                dabt;
  } wb_pkt_t;

  logic [0:0] state_q;
  logic [0:0] state_d;
  wb_pkt_t    pkt_q;
  wb_pkt_t    pkt_d;
  wb_pkt_t    pass_c;
  logic       unused_c;

  // Lane select and extension; byte beats halfword beats word when enables overlap.
  function automatic logic [31:0] align_load(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic        sbyte,
    input logic        ubyte,
    input logic        shalf,
    input logic        uhalf
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
`ifdef ZAP_UNALIGNED_ROTATE_EN
    logic [63:0] dd;
`endif
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    if (sbyte) begin
      r = {{24{b[7]}}, b};
    end else if (ubyte) begin
      r = {24'd0, b};
    end else if (shalf) begin
      r = {{16{h[15]}}, h};
    end else if (uhalf) begin
      r = {16'd0, h};
    end else begin
`ifdef ZAP_UNALIGNED_ROTATE_EN
      dd = {d, d} >> {a, 3'b000};
      r  = dd[31:0];
`else
      r  = d;
`endif
    end
    return r;
  endfunction

  // Only the lane bits of the address matter to this stage.
  assign unused_c = ^bus.i_mem_address_ff[31:2];

  // Straight pass-through packet for a normal non-stalled cycle.
  always_comb begin
    pass_c                   = '0;
    pass_c.dav               = bus.i_dav_ff;
    pass_c.uop_last          = bus.i_uop_last;
    pass_c.alu_result        = bus.i_alu_result_ff;
    pass_c.flags             = bus.i_flags_ff;
    pass_c.destination_index = bus.i_destination_index_ff;
    pass_c.mem_srcdest_index = bus.i_mem_srcdest_index_ff;
    pass_c.mem_load          = bus.i_mem_load_ff;
    pass_c.pc_plus_8         = bus.i_pc_plus_8_ff;
    pass_c.abt               = bus.i_abt_ff;
    pass_c.irq               = bus.i_irq_ff;
    pass_c.fiq               = bus.i_fiq_ff;
    pass_c.swi               = bus.i_swi_ff;
    pass_c.und               = bus.i_und_ff;
    pass_c.dabt              = 1'b0;
    pass_c.mem_rd_data       = bus.i_mem_load_ff ?
                               align_load(bus.i_data_rd_dat, bus.i_mem_address_ff[1:0],
                                          bus.i_mem_sbyte_enable_ff, bus.i_mem_ubyte_enable_ff,
                                          bus.i_mem_shalfword_enable_ff,
                                          bus.i_mem_uhalfword_enable_ff) : 32'd0;
  end

  // Next state and next packet: clear > stall > fault > normal.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    if (bus.i_clear_from_writeback) begin
      state_d      = ST_RUN;
      pkt_d.dav    = 1'b0;
      pkt_d.abt    = 1'b0;
      pkt_d.irq    = 1'b0;
      pkt_d.fiq    = 1'b0;
      pkt_d.swi    = 1'b0;
      pkt_d.und    = 1'b0;
      pkt_d.dabt   = 1'b0;
    end else if (!bus.i_data_stall) begin
      case (state_q)
        ST_RUN: begin
          pkt_d = pass_c;
          if (bus.i_data_mem_fault && bus.i_dav_ff) begin
            // Convert the faulting access into a single abort packet.
            state_d           = ST_SLEEP;
            pkt_d.dav         = 1'b0;
            pkt_d.mem_load    = 1'b0;
            pkt_d.mem_rd_data = 32'd0;
            pkt_d.abt         = 1'b0;
            pkt_d.irq         = 1'b0;
            pkt_d.fiq         = 1'b0;
            pkt_d.swi         = 1'b0;
            pkt_d.und         = 1'b0;
            pkt_d.dabt        = 1'b1;
          end
        end
        ST_SLEEP: begin
          pkt_d      = pass_c;
          pkt_d.dav  = 1'b0;
          pkt_d.abt  = 1'b0;
          pkt_d.irq  = 1'b0;
          pkt_d.fiq  = 1'b0;
          pkt_d.swi  = 1'b0;
          pkt_d.und  = 1'b0;
          pkt_d.dabt = 1'b0;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  assign bus.o_dav_ff               = pkt_q.dav;
  assign bus.o_uop_last             = pkt_q.uop_last;
  assign bus.o_alu_result_ff        = pkt_q.alu_result;
  assign bus.o_flags_ff             = pkt_q.flags;
  assign bus.o_destination_index_ff = pkt_q.destination_index;
  assign bus.o_mem_srcdest_index_ff = pkt_q.mem_srcdest_index;
  assign bus.o_mem_load_ff          = pkt_q.mem_load;
  assign bus.o_pc_plus_8_ff         = pkt_q.pc_plus_8;
  assign bus.o_abt_ff               = pkt_q.abt;
  assign bus.o_irq_ff               = pkt_q.irq;
  assign bus.o_fiq_ff               = pkt_q.fiq;
  assign bus.o_swi_ff               = pkt_q.swi;
  assign bus.o_und_ff               = pkt_q.und;
  assign bus.o_mem_rd_data_ff       = pkt_q.mem_rd_data;
  assign bus.o_dabt_ff              = pkt_q.dabt;

endmodule

// File: tb/tb_zap_load_align_main.sv
// Directed plus randomized bench for zap_load_align_main against a behavioural packet model.
module tb_zap_load_align_main;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  zap_load_align_main_if #(.PHY_REGS(46), .FLAG_WDT(32)) bus ();

  zap_load_align_main #(.PHY_REGS(46), .FLAG_WDT(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs; lvl says how much is defined: 0 valids only, 1 +pc/load, 2 everything.
  logic        e_dav, e_dabt, e_uop, e_load;
  logic [4:0]  e_exc;
  logic [31:0] e_alu, e_flags, e_pc, e_rd, e_dest, e_src;
  int          lvl;
  bit          m_sleep;

  function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [31:0] addr,
                                           input logic sb, input logic ub,
                                           input logic sh, input logic uh, input logic ld);
    int unsigned a;
    logic [31:0] v;
    a = addr % 4;
    if (!ld) return 32'd0;
    if (sb || ub) begin
      v = (d >> (8 * a)) & 32'h0000_00FF;
      if (sb && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sh || uh) begin
      v = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
      if (sh && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
`ifdef ZAP_UNALIGNED_ROTATE_EN
      v = (a == 0) ? d : ((d >> (8 * a)) | (d << (32 - 8 * a)));
`else
      v = d;
`endif
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    if (rst) begin
      {e_dav, e_dabt, e_uop, e_load} = '0;
      e_exc = '0; e_alu = '0; e_flags = '0; e_pc = '0; e_rd = '0; e_dest = '0; e_src = '0;
      lvl = 2; m_sleep = 0;
    end else if (bus.i_clear_from_writeback) begin
      e_dav = 0; e_dabt = 0; e_exc = '0; lvl = 0; m_sleep = 0;
    end else if (bus.i_data_stall) begin
      // hold
    end else if (m_sleep) begin
      e_dav = 0; e_dabt = 0; e_exc = '0; lvl = 0;
    end else if (bus.i_data_mem_fault && bus.i_dav_ff) begin
      e_dav = 0; e_dabt = 1; e_exc = '0; e_load = 0; e_pc = bus.i_pc_plus_8_ff;
      lvl = 1; m_sleep = 1;
    end else begin
      e_dav   = bus.i_dav_ff;
      e_dabt  = 0;
      e_uop   = bus.i_uop_last;
      e_load  = bus.i_mem_load_ff;
      e_exc   = {bus.i_abt_ff, bus.i_irq_ff, bus.i_fiq_ff, bus.i_swi_ff, bus.i_und_ff};
      e_alu   = bus.i_alu_result_ff;
      e_flags = bus.i_flags_ff;
      e_pc    = bus.i_pc_plus_8_ff;
      e_dest  = 32'(bus.i_destination_index_ff);
      e_src   = 32'(bus.i_mem_srcdest_index_ff);
      e_rd    = ref_data(bus.i_data_rd_dat, bus.i_mem_address_ff, bus.i_mem_sbyte_enable_ff,
                         bus.i_mem_ubyte_enable_ff, bus.i_mem_shalfword_enable_ff,
                         bus.i_mem_uhalfword_enable_ff, bus.i_mem_load_ff);
      lvl     = 2;
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".dav"}, 32'(bus.o_dav_ff), 32'(e_dav));
    chk({tag, ".dabt"}, 32'(bus.o_dabt_ff), 32'(e_dabt));
    chk({tag, ".exc"}, 32'({bus.o_abt_ff, bus.o_irq_ff, bus.o_fiq_ff, bus.o_swi_ff,
                            bus.o_und_ff}), 32'(e_exc));
    if (lvl >= 1) begin
      chk({tag, ".pc"}, bus.o_pc_plus_8_ff, e_pc);
      chk({tag, ".load"}, 32'(bus.o_mem_load_ff), 32'(e_load));
    end
    if (lvl == 2) begin
      chk({tag, ".alu"}, bus.o_alu_result_ff, e_alu);
      chk({tag, ".flags"}, bus.o_flags_ff, e_flags);
      chk({tag, ".dest"}, 32'(bus.o_destination_index_ff), e_dest);
      chk({tag, ".src"}, 32'(bus.o_mem_srcdest_index_ff), e_src);
      chk({tag, ".rd"}, bus.o_mem_rd_data_ff, e_rd);
      chk({tag, ".uop"}, 32'(bus.o_uop_last), 32'(e_uop));
    end
  endtask

  task automatic rand_fields();
    int unsigned k;
    bus.i_dav_ff               = ($urandom_range(0, 9) < 7);
    bus.i_uop_last             = 1'($urandom);
    bus.i_alu_result_ff        = $urandom;
    bus.i_flags_ff             = $urandom;
    bus.i_destination_index_ff = 6'($urandom_range(0, 45));
    bus.i_mem_srcdest_index_ff = 6'($urandom_range(0, 45));
    bus.i_mem_load_ff          = ($urandom_range(0, 9) < 6);
    bus.i_mem_address_ff       = $urandom;
    bus.i_pc_plus_8_ff         = $urandom;
    bus.i_data_rd_dat          = $urandom;
    {bus.i_abt_ff, bus.i_irq_ff, bus.i_fiq_ff, bus.i_swi_ff, bus.i_und_ff} =
      ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
    k = $urandom_range(0, 4);
    bus.i_mem_sbyte_enable_ff     = (k == 1);
    bus.i_mem_ubyte_enable_ff     = (k == 2);
    bus.i_mem_shalfword_enable_ff = (k == 3);
    bus.i_mem_uhalfword_enable_ff = (k == 4);
  endtask

  // kind: 0 word, 1 sbyte, 2 ubyte, 3 shalf, 4 uhalf
  task automatic set_load(input logic [31:0] addr, input logic [31:0] d, input int kind);
    rand_fields();
    bus.i_dav_ff = 1; bus.i_mem_load_ff = 1;
    bus.i_mem_address_ff = addr; bus.i_data_rd_dat = d;
    bus.i_mem_sbyte_enable_ff     = (kind == 1);
    bus.i_mem_ubyte_enable_ff     = (kind == 2);
    bus.i_mem_shalfword_enable_ff = (kind == 3);
    bus.i_mem_uhalfword_enable_ff = (kind == 4);
  endtask

  initial begin
    checks = 0; failures = 0; lvl = 0; m_sleep = 0;
    rst = 1;
    bus.i_clear_from_writeback = 0; bus.i_data_stall = 0; bus.i_data_mem_fault = 0;
    rand_fields();
    tick("reset");
    chk("reset.rd_zero", bus.o_mem_rd_data_ff, 32'd0);
    rst = 0;

    set_load(32'h0000_1002, 32'hAABB_CCDD, 0);
    tick("word");
`ifdef ZAP_UNALIGNED_ROTATE_EN
    chk("word.const", bus.o_mem_rd_data_ff, 32'hCCDD_AABB);
`else
    chk("word.const", bus.o_mem_rd_data_ff, 32'hAABB_CCDD);
`endif
    set_load(32'h0000_2003, 32'h8011_2233, 1);
    tick("sbyte");
    chk("sbyte.const", bus.o_mem_rd_data_ff, 32'hFFFF_FF80);
    set_load(32'h0000_2003, 32'h8011_2233, 2);
    tick("ubyte");
    chk("ubyte.const", bus.o_mem_rd_data_ff, 32'h0000_0080);
    set_load(32'h0000_3002, 32'h8001_1234, 3);
    tick("shalf");
    chk("shalf.const", bus.o_mem_rd_data_ff, 32'hFFFF_8001);
    set_load(32'h0000_3000, 32'h8001_1234, 4);
    tick("uhalf");
    chk("uhalf.const", bus.o_mem_rd_data_ff, 32'h0000_1234);
    rand_fields(); bus.i_mem_load_ff = 0;
    tick("noload");
    chk("noload.const", bus.o_mem_rd_data_ff, 32'd0);

    // Stall for 3 cycles with changing inputs, then release.
    set_load(32'h0000_0001, 32'h1234_5678, 2);
    tick("pre_stall");
    bus.i_data_stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.i_data_mem_fault = 1;
      tick("stall");
      chk("stall.rd_hold", bus.o_mem_rd_data_ff, 32'h0000_0056);
    end
    bus.i_data_stall = 0; bus.i_data_mem_fault = 0;
    set_load(32'h0000_0000, 32'h0000_00FF, 1);
    tick("post_stall");
    chk("post_stall.const", bus.o_mem_rd_data_ff, 32'hFFFF_FFFF);

    // Fault on a valid load, then sleep.
    set_load(32'h0000_0000, 32'h1111_2222, 0);
    bus.i_pc_plus_8_ff = 32'h0000_4008;
    bus.i_data_mem_fault = 1;
    tick("fault");
    chk("fault.dabt_const", 32'(bus.o_dabt_ff), 32'd1);
    chk("fault.pc_const", bus.o_pc_plus_8_ff, 32'h0000_4008);
    bus.i_data_mem_fault = 0;
    for (int i = 0; i < 4; i++) begin
      rand_fields(); bus.i_dav_ff = 1;
      tick("sleep");
      chk("sleep.dav_const", 32'(bus.o_dav_ff), 32'd0);
    end
    bus.i_clear_from_writeback = 1;
    tick("clear");
    bus.i_clear_from_writeback = 0;
    set_load(32'h0000_0002, 32'hDEAD_BEEF, 4);
    tick("after_clear");
    chk("after_clear.dav_const", 32'(bus.o_dav_ff), 32'd1);

    // Reset and clear together in the middle of a stall.
    bus.i_data_stall = 1;
    rand_fields();
    tick("stall2");
    rst = 1; bus.i_clear_from_writeback = 1;
    tick("rst_clr");
    chk("rst_clr.alu_zero", bus.o_alu_result_ff, 32'd0);
    rst = 0; bus.i_clear_from_writeback = 0; bus.i_data_stall = 0;
    set_load(32'h0000_0001, 32'h0000_7F00, 1);
    tick("rst_clr_run");
    chk("rst_clr_run.const", bus.o_mem_rd_data_ff, 32'h0000_007F);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      bus.i_data_stall           = ($urandom_range(0, 3) == 0);
      bus.i_data_mem_fault       = ($urandom_range(0, 9) == 0);
      bus.i_clear_from_writeback = ($urandom_range(0, 19) == 0);
      rst                        = ($urandom_range(0, 49) == 0);
      tick("rand");
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
